// File: rtl/ram_arb_pkg.sv
// Shared types and default sizing for the ram_1h two-requester arbiter.
package ram_arb_pkg;

  localparam int ADDR_W_DEF   = 11;
  localparam int DATA_W_DEF   = 8;
  localparam int MAX_WAIT_DEF = 4;

  // Owner tag carried alongside each in-flight RAM read.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

endpackage

// File: rtl/ram_arb_starve_ctr.sv
// Saturating count of cycles in which B requested but lost; raises force_b
// once B has lost MAX_WAIT cycles in a row.
module ram_arb_starve_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic b_req,
  input  logic b_ack,
  output logic force_b
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (!b_req || b_ack) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MAX_CNT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign force_b = (wait_cnt == MAX_CNT);

endmodule

// File: rtl/ram_1h_arbiter.sv
// Two-requester arbiter in front of a single-port registered-read RAM; A has priority.
// Optional starvation guard for B: define RAM_ARB_STARVE_GUARD_EN.
module ram_1h_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_clken,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q
);

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("ram_1h_arbiter: MAX_WAIT must be at least 1");
  end

  logic              force_b;
  logic              a_grant;
  logic              b_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  owner_t            s1_own;
  owner_t            s1_nxt;
  owner_t            s2_own;

`ifdef RAM_ARB_STARVE_GUARD_EN
  ram_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clock   (clock),
    .reset_n (reset_n),
    .b_req   (b_req),
    .b_ack   (b_grant),
    .force_b (force_b)
  );
`else
  assign force_b = 1'b0;
`endif

  // A wins unless the starvation guard has handed this cycle to a waiting B.
  assign a_grant = a_req & ~(force_b & b_req);
  assign b_grant = b_req & ~a_grant;
  assign a_ack   = a_grant;
  assign b_ack   = b_grant;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    ram_clken   = 1'b0;
    ram_wren    = 1'b0;
    ram_address = addr_q;
    ram_data    = data_q;
    s1_nxt      = OWN_NONE;
    if (a_grant) begin
      ram_clken   = 1'b1;
      ram_wren    = a_we;
      ram_address = a_addr;
      ram_data    = a_wdata;
      s1_nxt      = a_we ? OWN_NONE : OWN_A;
    end else if (b_grant) begin
      ram_clken   = 1'b1;
      ram_wren    = b_we;
      ram_address = b_addr;
      ram_data    = b_wdata;
      s1_nxt      = b_we ? OWN_NONE : OWN_B;
    end
  end

  // Idle cycles keep presenting the last granted address/data to the RAM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (ram_clken) begin
      addr_q <= ram_address;
      data_q <= ram_data;
    end
  end

  // Stage 1 tags the cycle in which ram_q is valid; stage 2 is the rvalid cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_own  <= OWN_NONE;
      s2_own  <= OWN_NONE;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      s1_own <= s1_nxt;
      s2_own <= s1_own;
      if (s1_own == OWN_A) a_rdata <= ram_q;
      if (s1_own == OWN_B) b_rdata <= ram_q;
    end
  end

  assign a_rvalid = (s2_own == OWN_A);
  assign b_rvalid = (s2_own == OWN_B);

endmodule

// File: tb/tb_ram_1h_arbiter.sv
// Directed bench for ram_1h_arbiter with a behavioural registered-read RAM and
// a read-data scoreboard; expectations follow RAM_ARB_STARVE_GUARD_EN when defined.
module tb_ram_1h_arbiter;
  import ram_arb_pkg::*;

  localparam int AW = 11;
  localparam int DW = 8;

`ifdef RAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clock;
  logic          reset_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ack, a_rvalid, b_ack, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_clken, ram_wren;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  typedef struct {
    owner_t        own;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  ram_1h_arbiter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_ack       (a_ack),
    .a_rvalid    (a_rvalid),
    .a_rdata     (a_rdata),
    .b_req       (b_req),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .b_ack       (b_ack),
    .b_rvalid    (b_rvalid),
    .b_rdata     (b_rdata),
    .ram_clken   (ram_clken),
    .ram_wren    (ram_wren),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_q       (ram_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural ram_1h: write-at-edge, registered read data one cycle later.
  always @(posedge clock) begin
    if (ram_clken) begin
      if (ram_wren) mem[ram_address] <= ram_data;
      else          ram_q <= mem[ram_address];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every rvalid pulse must match the oldest expected read, in the expected cycle.
  always @(negedge clock) begin
    if (a_rvalid || b_rvalid) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", {30'b0, a_rvalid, b_rvalid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("a_rvalid", a_rvalid, mon_e.own == OWN_A);
        check("b_rvalid", b_rvalid, mon_e.own == OWN_B);
        check("rdata", (mon_e.own == OWN_A) ? a_rdata : b_rdata, mon_e.data);
        check("rvalid_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // One cycle of stimulus, entered and left just after a falling edge.
  task automatic step(input logic ar, input logic aw, input logic [AW-1:0] aa,
                      input logic [DW-1:0] ad, input logic br, input logic bw,
                      input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input logic ea, input logic eb, input logic [DW-1:0] ed);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
    check("a_ack", a_ack, ea);
    check("b_ack", b_ack, eb);
    check("ram_clken", ram_clken, ea | eb);
    if (ea) begin
      check("ram_wren_a", ram_wren, aw);
      check("ram_address_a", ram_address, aa);
      if (aw) check("ram_data_a", ram_data, ad);
      else    sb.push_back('{OWN_A, ed, cyc + 2});
    end else if (eb) begin
      check("ram_wren_b", ram_wren, bw);
      check("ram_address_b", ram_address, ba);
      if (bw) check("ram_data_b", ram_data, bd);
      else    sb.push_back('{OWN_B, ed, cyc + 2});
    end else begin
      check("ram_wren_idle", ram_wren, 1'b0);
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, '0);
  endtask

  // A reads 0x020, B reads 0x030, both held; guard build hands cycle 5 to B.
  task automatic contend(input int n);
    for (int i = 1; i <= n; i++) begin
      if (GUARD && i == 5) step(1, 0, 11'h020, '0, 1, 0, 11'h030, '0, 0, 1, 8'hB0);
      else                 step(1, 0, 11'h020, '0, 1, 0, 11'h030, '0, 1, 0, 8'hA0);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[11'h000] = 8'h11; mem[11'h001] = 8'h22;
    mem[11'h002] = 8'h33; mem[11'h003] = 8'h44;
    mem[11'h020] = 8'hA0; mem[11'h030] = 8'hB0;
    ram_q = '0;
    reset_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;

    #3;
    check("rst_a_rvalid", a_rvalid, 1'b0);
    check("rst_b_rvalid", b_rvalid, 1'b0);
    check("rst_a_rdata", a_rdata, 8'h00);
    check("rst_b_rdata", b_rdata, 8'h00);
    check("rst_ram_address", ram_address, 11'h000);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // 1: A write then read-after-write of the same address.
    step(1, 1, 11'h010, 8'h5A, 0, 0, '0, '0, 1, 0, '0);
    step(1, 0, 11'h010, 8'h00, 0, 0, '0, '0, 1, 0, 8'h5A);
    idle(3);

    // 2: both requesting continuously.
    contend(8);
    idle(3);

    // 3: B back-to-back reads, pulses on consecutive cycles.
    step(0, 0, '0, '0, 1, 0, 11'h000, '0, 0, 1, 8'h11);
    step(0, 0, '0, '0, 1, 0, 11'h001, '0, 0, 1, 8'h22);
    step(0, 0, '0, '0, 1, 0, 11'h002, '0, 0, 1, 8'h33);
    step(0, 0, '0, '0, 1, 0, 11'h003, '0, 0, 1, 8'h44);
    idle(3);

    // 4: B accumulates losses, A read in flight, then reset drops it.
    step(1, 1, 11'h100, 8'h77, 1, 0, 11'h030, '0, 1, 0, '0);
    a_req = 1; a_we = 0; a_addr = 11'h010; b_req = 1; b_we = 0; b_addr = 11'h030;
    #1;
    check("inflight_a_ack", a_ack, 1'b1);
    @(posedge clock);
    @(negedge clock);
    a_req = 0; b_req = 0;
    reset_n = 1'b0;
    #1;
    check("rst2_a_rvalid", a_rvalid, 1'b0);
    check("rst2_a_rdata", a_rdata, 8'h00);
    check("rst2_b_rdata", b_rdata, 8'h00);
    check("rst2_ram_address", ram_address, 11'h000);
    check("rst2_ram_data", ram_data, 8'h00);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    idle(2);
    contend(5);
    idle(3);

    // 5: idle stretch, nothing issued or returned.
    idle(10);

    // 6: A write at the top address, B reads it back the next cycle.
    step(1, 1, 11'h7FF, 8'hC3, 0, 0, '0, '0, 1, 0, '0);
    step(0, 0, '0, '0, 1, 0, 11'h7FF, '0, 0, 1, 8'hC3);
    idle(1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
